// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: turns the free-running system clock into a
// one-cycle CPU clock-enable. The enable rate comes from a programmable
// divider. The operator can also single-step the CPU. A halt request from
// the CPU freezes it until the run switch is turned off.
module cpu_clk_ctrl #(
   parameter logic [27:0] DEFAULT_SCALE = 28'd24_999_999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run_sw,
   input  logic        step_btn,
   input  logic        halt_req,
   input  logic        scale_load,
   input  logic [27:0] scale_in,
   output logic        cpu_en,
   output logic        scale_ack,
   output logic [1:0]  state,
   output logic [15:0] tick_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      STEP   = 2'b10,
      HALTED = 2'b11
   } state_t;

   state_t      cur_state;
   state_t      nxt_state;
   logic [27:0] cnt;
   logic [27:0] cnt_nxt;
   logic [27:0] scale_reg;
   logic        step_prev;
   logic        step_edge;
   logic        at_term;
   logic        en_nxt;

   assign step_edge = step_btn & ~step_prev;
   assign at_term   = (cnt == scale_reg);
   assign state     = cur_state;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state logic. Run beats step in IDLE, and halt beats stop in RUN.
   // Step edges are ignored outside IDLE.
   always_comb begin
      nxt_state = cur_state;
      unique case (cur_state)
         IDLE: begin
            if (run_sw)         nxt_state = RUN;
            else if (step_edge) nxt_state = STEP;
         end
         RUN: begin
            if (halt_req)     nxt_state = HALTED;
            else if (!run_sw) nxt_state = IDLE;
         end
         STEP:    nxt_state = IDLE;
         HALTED: begin
            if (!run_sw) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Output/divider logic. Decides whether the next cycle carries a CPU
   // enable and what the divider counter becomes. A pending RUN pulse is
   // dropped when the FSM leaves RUN or the scale is reloaded.
   always_comb begin
      en_nxt  = 1'b0;
      cnt_nxt = '0;
      unique case (cur_state)
         RUN: begin
            if (nxt_state == RUN) begin
               if (at_term) en_nxt = 1'b1;
               else         cnt_nxt = cnt + 28'd1;
            end
         end
         STEP:    en_nxt = 1'b1;
         default: ;
      endcase
      if (scale_load) begin
         cnt_nxt = '0;
         if (cur_state == RUN) en_nxt = 1'b0;
      end
   end

   // Divider, scale, edge-detect and registered outputs. tick_cnt advances
   // on the same edge that raises cpu_en, so it already includes the
   // current pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         scale_reg <= DEFAULT_SCALE;
         step_prev <= 1'b0;
         cpu_en    <= 1'b0;
         scale_ack <= 1'b0;
         tick_cnt  <= '0;
      end else begin
         cnt       <= cnt_nxt;
         step_prev <= step_btn;
         cpu_en    <= en_nxt;
         scale_ack <= scale_load;
         tick_cnt  <= tick_cnt + {15'd0, en_nxt};
         if (scale_load) scale_reg <= scale_in;
      end
   end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl. Directed scenarios check the documented timing
// with literal expectations. A randomized run compares every cycle
// against a behavioural model of the controller.
module tb_cpu_clk_ctrl;

   localparam logic [27:0] DEF = 28'd6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run_sw = 1'b0;
   logic        step_btn = 1'b0;
   logic        halt_req = 1'b0;
   logic        scale_load = 1'b0;
   logic [27:0] scale_in = '0;
   logic        cpu_en;
   logic        scale_ack;
   logic [1:0]  state;
   logic [15:0] tick_cnt;

   int checks = 0;
   int failures = 0;

   cpu_clk_ctrl #(.DEFAULT_SCALE(DEF)) dut (
      .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
      .halt_req(halt_req), .scale_load(scale_load), .scale_in(scale_in),
      .cpu_en(cpu_en), .scale_ack(scale_ack), .state(state), .tick_cnt(tick_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode, phase of the divider, programmed period.
   logic [1:0]  m_state;
   int unsigned m_phase;
   int unsigned m_scale;
   logic        m_prev;
   logic        m_en;
   logic        m_ack;
   logic [15:0] m_tick;

   task automatic model_reset();
      m_state = 2'd0; m_phase = 0; m_scale = DEF; m_prev = 1'b0;
      m_en = 1'b0; m_ack = 1'b0; m_tick = 16'd0;
   endtask

   task automatic model_update();
      bit          edge_seen;
      bit          pulse;
      logic [1:0]  ns;
      int unsigned ph;
      edge_seen = step_btn && !m_prev;
      pulse = 0;
      ns = m_state;
      ph = 0;
      if (m_state == 2'd0) begin
         if (run_sw) ns = 2'd1;
         else if (edge_seen) ns = 2'd2;
      end else if (m_state == 2'd1) begin
         if (halt_req) ns = 2'd3;
         else if (!run_sw) ns = 2'd0;
         else if (m_phase == m_scale) pulse = 1;
         else ph = m_phase + 1;
      end else if (m_state == 2'd2) begin
         ns = 2'd0;
         pulse = 1;
      end else begin
         if (!run_sw) ns = 2'd0;
      end
      if (scale_load) begin
         if (m_state == 2'd1) pulse = 0;
         ph = 0;
         m_scale = scale_in;
      end
      m_state = ns;
      m_phase = ph;
      m_en = pulse;
      m_ack = scale_load;
      m_tick = m_tick + (pulse ? 16'd1 : 16'd0);
      m_prev = step_btn;
   endtask

   // One clock: advance the model with the inputs sampled at the edge,
   // then move to 1 time unit past the edge for sampling and driving.
   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; run_sw = 0; step_btn = 0; halt_req = 0; scale_load = 0; scale_in = '0;
      cycle();
      rst = 1'b0;
   endtask

   task automatic load_scale(input logic [27:0] v);
      scale_load = 1'b1; scale_in = v;
      cycle();
      scale_load = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({state, cpu_en, scale_ack, tick_cnt} !== 20'd0) begin
         failures++;
         $display("FAIL reset_state: got st=%0d en=%0b ack=%0b tick=%0d, want all 0", state, cpu_en, scale_ack, tick_cnt);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cycle();
      checks++;
      if (state !== 2'd0 || cpu_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: got st=%0d en=%0b, want st=0 en=0", state, cpu_en);
      end
   endtask

   task automatic test_run_scale3();
      int last = -1;
      int npulse = 0;
      do_reset();
      load_scale(28'd3);
      checks++;
      if (scale_ack !== 1'b1) begin
         failures++; $display("FAIL run3_ack_high: got %0b want 1", scale_ack);
      end
      run_sw = 1'b1;
      cycle();
      checks++;
      if (scale_ack !== 1'b0 || state !== 2'd1) begin
         failures++; $display("FAIL run3_ack_drop: got ack=%0b st=%0d want ack=0 st=1", scale_ack, state);
      end
      for (int i = 0; i < 40 && npulse < 5; i++) begin
         cycle();
         if (cpu_en) begin
            checks++;
            if ((last < 0 && i != 3) || (last >= 0 && i - last != 4)) begin
               failures++; $display("FAIL run3_period: pulse at %0d, previous %0d, want first at 3 then every 4", i, last);
            end
            last = i;
            npulse++;
         end
      end
      checks++;
      if (npulse != 5 || tick_cnt !== 16'd5) begin
         failures++; $display("FAIL run3_tick: got pulses=%0d tick=%0d want 5/5", npulse, tick_cnt);
      end
   endtask

   task automatic test_step();
      logic [1:0] est;
      logic       een;
      do_reset();
      load_scale(28'd9);
      step_btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         est = (i == 0) ? 2'd2 : 2'd0;
         een = (i == 1);
         checks++;
         if (state !== est || cpu_en !== een) begin
            failures++; $display("FAIL step_seq cyc %0d: got st=%0d en=%0b want st=%0d en=%0b", i, state, cpu_en, est, een);
         end
      end
      step_btn = 1'b0;
      checks++;
      if (tick_cnt !== 16'd1) begin
         failures++; $display("FAIL step_tick: got %0d want 1", tick_cnt);
      end
   endtask

   task automatic test_halt();
      do_reset();
      load_scale(28'd2);
      run_sw = 1'b1;
      repeat (3) cycle();
      checks++;
      if (state !== 2'd1 || cpu_en !== 1'b0) begin
         failures++; $display("FAIL halt_pre: got st=%0d en=%0b want st=1 en=0", state, cpu_en);
      end
      halt_req = 1'b1;
      cycle();
      checks++;
      if (state !== 2'd3 || cpu_en !== 1'b0) begin
         failures++; $display("FAIL halt_enter: got st=%0d en=%0b want st=3 en=0", state, cpu_en);
      end
      halt_req = 1'b0;
      step_btn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (state !== 2'd3 || cpu_en !== 1'b0) begin
            failures++; $display("FAIL halt_hold cyc %0d: got st=%0d en=%0b want st=3 en=0", i, state, cpu_en);
         end
      end
      step_btn = 1'b0;
      run_sw = 1'b0;
      cycle();
      checks++;
      if (state !== 2'd0 || tick_cnt !== 16'd0) begin
         failures++; $display("FAIL halt_exit: got st=%0d tick=%0d want st=0 tick=0", state, tick_cnt);
      end
   endtask

   task automatic test_wrap();
      int high = 0;
      do_reset();
      load_scale(28'd0);
      run_sw = 1'b1;
      cycle();
      cycle();
      checks++;
      if (cpu_en !== 1'b1 || tick_cnt !== 16'd1) begin
         failures++; $display("FAIL wrap_first: got en=%0b tick=%0d want en=1 tick=1", cpu_en, tick_cnt);
      end
      high = 1;
      for (int i = 1; i < 65536; i++) begin
         cycle();
         if (cpu_en === 1'b1) high++;
      end
      checks++;
      if (high != 65536 || tick_cnt !== 16'd0) begin
         failures++; $display("FAIL wrap_tick: got high=%0d tick=%0d want 65536/0", high, tick_cnt);
      end
      run_sw = 1'b0;
      cycle();
   endtask

   task automatic test_async_reset();
      int last = -1;
      int npulse = 0;
      do_reset();
      load_scale(28'd5);
      run_sw = 1'b1;
      repeat (4) cycle();
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({state, cpu_en, scale_ack, tick_cnt} !== 20'd0) begin
         failures++; $display("FAIL async_reset: got st=%0d en=%0b ack=%0b tick=%0d want all 0", state, cpu_en, scale_ack, tick_cnt);
      end
      model_reset();
      #2 rst = 1'b0;
      for (int i = 0; i < 40 && npulse < 2; i++) begin
         cycle();
         if (cpu_en) begin
            if (last >= 0) begin
               checks++;
               if (i - last != int'(DEF) + 1) begin
                  failures++; $display("FAIL async_default_period: got %0d want %0d", i - last, int'(DEF) + 1);
               end
            end
            last = i;
            npulse++;
         end
      end
      checks++;
      if (npulse != 2) begin
         failures++; $display("FAIL async_timeout: got pulses=%0d want 2", npulse);
      end
      run_sw = 1'b0;
      cycle();
   endtask

   task automatic test_load_coincide();
      int waited = 0;
      do_reset();
      load_scale(28'd7);
      run_sw = 1'b1;
      cycle();
      while (cpu_en !== 1'b1 && waited < 20) begin
         cycle();
         waited++;
      end
      checks++;
      if (cpu_en !== 1'b1) begin
         failures++; $display("FAIL coincide_timeout: got en=%0b want 1", cpu_en);
      end
      repeat (7) cycle();
      scale_load = 1'b1; scale_in = 28'd1;
      cycle();
      scale_load = 1'b0;
      checks++;
      if (cpu_en !== 1'b0 || scale_ack !== 1'b1) begin
         failures++; $display("FAIL coincide_suppress: got en=%0b ack=%0b want en=0 ack=1", cpu_en, scale_ack);
      end
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (cpu_en !== (i % 2 == 1)) begin
            failures++; $display("FAIL coincide_period cyc %0d: got en=%0b want %0b", i, cpu_en, (i % 2 == 1));
         end
      end
      run_sw = 1'b0;
      cycle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      scale_load = 1'b1; scale_in = 28'd9;
      cycle();
      scale_in = 28'd2;
      cycle();
      checks++;
      if (scale_ack !== 1'b1) begin
         failures++; $display("FAIL b2b_ack: got %0b want 1", scale_ack);
      end
      scale_load = 1'b0;
      run_sw = 1'b1;
      cycle();
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (cpu_en !== (i % 3 == 2)) begin
            failures++; $display("FAIL b2b_period cyc %0d: got en=%0b want %0b", i, cpu_en, (i % 3 == 2));
         end
      end
      run_sw = 1'b0;
      cycle();
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(19) == 0) run_sw = ~run_sw;
         halt_req = ($urandom_range(15) == 0);
         if ($urandom_range(3) == 0) step_btn = ~step_btn;
         scale_load = ($urandom_range(24) == 0);
         scale_in = 28'($urandom_range(5));
         cycle();
         checks++;
         if ({state, cpu_en, scale_ack, tick_cnt} !== {m_state, m_en, m_ack, m_tick}) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random cyc %0d: got st=%0d en=%0b ack=%0b tick=%0d want st=%0d en=%0b ack=%0b tick=%0d",
                        i, state, cpu_en, scale_ack, tick_cnt, m_state, m_en, m_ack, m_tick);
         end
      end
      run_sw = 0; halt_req = 0; step_btn = 0; scale_load = 0;
      cycle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_scale3();
      test_step();
      test_halt();
      test_wrap();
      test_async_reset();
      test_load_coincide();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
